// File: rtl/serial_word_tx_pkg.sv
// rtl/serial_word_tx_pkg.sv - shared FSM state encoding and line defaults for the serial stage
//
// Purpose: state encoding (IDLE=0, SHIFT=1) and the default idle line level.
//          The downstream pattern-detector stage imports the same definitions.
//          Also provides the bit-counter width helper.
package serial_word_tx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

  localparam logic DEF_IDLE_LEVEL = 1'b1;

  // Bit counter width; $clog2 alone would give 1 for WIDTH=2, which is
  // already correct, but a one-bit floor keeps the helper safe for all WIDTHs.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_word_tx_word_hold_reg.sv
// rtl/serial_word_tx_word_hold_reg.sv - one-word holding register with full flag
//
// Purpose: parks the next word while the shifter is still busy with the current one.
// Ports:
//   clk        clock
//   reset      asynchronous, active-low
//   load       capture load_data and set full
//   load_data  word to capture
//   drain      shifter has taken the held word; clear full
//   full       a word is held
//   data       held word
module word_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  // load and drain are mutually exclusive in the parent: load only happens
  // on a non-last shift cycle, drain only on the last one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - parallel-to-serial word transmitter with one-word holding register
//
// Purpose: accepts WIDTH-bit words on a valid/ready handshake and shifts them out one
//          bit per clock on ser_out, back-to-back with no gap when a next word is ready.
// Ports:
//   clk         clock
//   reset       asynchronous, active-low
//   in_data     word to serialise, sampled on the accept edge
//   in_valid    in_data is valid
//   in_ready    a word can be taken (no word currently held)
//   ser_out     serial bit stream, IDLE_LEVEL between words
//   ser_active  a word bit is on ser_out
//   word_done   last bit of a word is on ser_out
module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_active,
  output logic             word_done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  ser_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_adv;
  logic             busy;
  logic             last;
  logic             accept;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             hold_load;
  logic             hold_drain;

  assign busy   = (state == ST_SHIFT);
  assign last   = busy && (cnt == CNT_LAST);
  assign accept = in_valid && !hold_full;

  // A word arriving mid-shift is parked; on the last bit the held word
  // takes priority, and in_ready is low then so no new word can compete.
  assign hold_load  = accept && busy && !last;
  assign hold_drain = last && hold_full;

  word_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (hold_load),
    .load_data (in_data),
    .drain     (hold_drain),
    .full      (hold_full),
    .data      (hold_data)
  );

  // The outgoing bit always sits at one end of the shifter; advancing
  // moves the next bit into that position.
  always_comb begin
    shreg_adv = shreg;
    if (MSB_FIRST) begin
      shreg_adv = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      shreg_adv = {1'b0, shreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg <= in_data;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (!last) begin
            shreg <= shreg_adv;
            cnt   <= cnt + CW'(1);
          end else if (hold_full) begin
            shreg <= hold_data;
            cnt   <= '0;
          end else if (accept) begin
            shreg <= in_data;
            cnt   <= '0;
          end else begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign in_ready   = !hold_full;
  assign ser_active = busy;
  assign word_done  = last;
  assign ser_out    = busy ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : IDLE_LEVEL;

endmodule

// File: tb/tb_serial_word_tx.sv
// tb/tb_serial_word_tx.sv - directed self-checking bench for serial_word_tx
module tb_serial_word_tx;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ser_out;
  logic       ser_active;
  logic       word_done;

  logic [7:0] in_data2;
  logic       in_valid2;
  logic       in_ready2;
  logic       ser_out2;
  logic       ser_active2;
  logic       word_done2;

  int checks;
  int failures;

  serial_word_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ser_out    (ser_out),
    .ser_active (ser_active),
    .word_done  (word_done)
  );

  serial_word_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_lsb (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data2),
    .in_valid   (in_valid2),
    .in_ready   (in_ready2),
    .ser_out    (ser_out2),
    .ser_active (ser_active2),
    .word_done  (word_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  w;
    logic [15:0] stream;
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_data2  = 8'h00;
    in_valid2 = 1'b0;

    // 1. reset state and idle line
    tick();
    check("rst_ser_out", ser_out, 1);
    check("rst_active", ser_active, 0);
    check("rst_ready", in_ready, 1);
    check("rst_done", word_done, 0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_ser_out", ser_out, 1);
      check("idle_active", ser_active, 0);
      check("idle_ready", in_ready, 1);
    end

    // 2. single word 8'h33, MSB first
    w        = 8'h33;
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = 8'hCC;
    for (int i = 0; i < 8; i++) begin
      check("w33_bit", ser_out, w[7-i]);
      check("w33_active", ser_active, 1);
      check("w33_done", word_done, (i == 7));
      tick();
    end
    check("w33_idle_out", ser_out, 1);
    check("w33_idle_active", ser_active, 0);
    check("w33_idle_done", word_done, 0);

    // 3. back-to-back A5 then 0F through the holding register
    stream   = 16'hA50F;
    in_data  = 8'hA5;
    in_valid = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      check("b2b_bit", ser_out, stream[15-i]);
      check("b2b_active", ser_active, 1);
      check("b2b_done", word_done, (i == 7) || (i == 15));
      check("b2b_ready", in_ready, (i == 0) || (i >= 8));
      if (i == 0) in_data = 8'h0F;
      if (i == 1) begin
        in_valid = 1'b0;
        in_data  = 8'h00;
      end
      tick();
    end
    check("b2b_idle_out", ser_out, 1);
    check("b2b_idle_active", ser_active, 0);
    check("b2b_idle_ready", in_ready, 1);

    // 4. LSB-first instance with 8'h01
    w         = 8'h01;
    in_data2  = w;
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("lsb_bit", ser_out2, w[i]);
      check("lsb_done", word_done2, (i == 7));
      tick();
    end
    check("lsb_idle_out", ser_out2, 1);
    check("lsb_idle_active", ser_active2, 0);

    // 5. reset in the middle of 8'hFF with 8'h00 held
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_data  = 8'h00;
    tick();
    in_valid = 1'b0;
    check("abort_held", in_ready, 0);
    tick();
    tick();
    tick();
    check("abort_bit4_pre", ser_out, 1);
    check("abort_active_pre", ser_active, 1);
    reset = 1'b0;
    #1;
    check("abort_out", ser_out, 1);
    check("abort_active", ser_active, 0);
    check("abort_ready_in_rst", in_ready, 1);
    tick();
    reset = 1'b1;
    tick();
    check("abort_ready", in_ready, 1);
    for (int i = 0; i < 20; i++) begin
      check("abort_quiet_out", ser_out, 1);
      check("abort_quiet_active", ser_active, 0);
      check("abort_quiet_done", word_done, 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
